// File: rtl/fifo_p2s_serializer_if.sv
// fifo_p2s_serializer_if: FIFO read port plus valid/ready serial bit stream.
interface fifo_p2s_serializer_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_pop_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_data;
    logic             ser_first;
    logic             ser_last;
    modport master (
        input  fifo_empty, fifo_pop_data, ser_ready,
        output fifo_pop, ser_valid, ser_data, ser_first, ser_last
    );
    modport slave (
        output fifo_empty, fifo_pop_data, ser_ready,
        input  fifo_pop, ser_valid, ser_data, ser_first, ser_last
    );
endinterface

// File: rtl/fifo_p2s_serializer.sv
// fifo_p2s_serializer: pops FIFO words and shifts them out one bit per accepted cycle.
module fifo_p2s_serializer #(
    parameter int FIFO_WIDTH = 8,
    parameter bit LSB_FIRST  = 0,
    parameter int IDLE_GAP   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    fifo_p2s_serializer_if.master         bus,
    output logic                          busy,
    output logic [15:0]                   words_sent
);
    localparam int CW = $clog2(FIFO_WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t                state;
    logic [FIFO_WIDTH-1:0] shreg;
    logic [CW-1:0]         bit_cnt;
    logic [3:0]            gap_cnt;
    logic                  accept;
    logic                  last;
    assign accept        = state == SHIFT && bus.ser_ready;
    assign last          = accept && bit_cnt == '0;
    // Back-to-back reload on the last bit only when no gap is requested
    assign bus.fifo_pop  = !rst && !bus.fifo_empty && (state == IDLE || (last && IDLE_GAP == 0));
    assign bus.ser_valid = state == SHIFT;
    assign bus.ser_data  = LSB_FIRST ? shreg[0] : shreg[FIFO_WIDTH-1];
    assign bus.ser_first = state == SHIFT && bit_cnt == CW'(FIFO_WIDTH - 1);
    assign bus.ser_last  = state == SHIFT && bit_cnt == '0;
    assign busy          = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            words_sent <= '0;
        end else begin
            if (bus.fifo_pop) begin
                shreg   <= bus.fifo_pop_data;
                bit_cnt <= CW'(FIFO_WIDTH - 1);
                state   <= SHIFT;
            end else if (accept) begin
                shreg   <= LSB_FIRST ? shreg >> 1 : shreg << 1;
                bit_cnt <= bit_cnt - CW'(1);
            end
            if (last) words_sent <= words_sent + 16'd1;
            if (last && !bus.fifo_pop) begin
                state   <= IDLE_GAP > 0 ? GAP : IDLE;
                gap_cnt <= 4'(IDLE_GAP - 1);
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt - 4'd1;
                if (gap_cnt == '0) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fifo_p2s_serializer.sv
// tb_fifo_p2s_serializer: three DUT lanes (MSB/no gap, LSB/no gap, MSB/gap 2) checked
// every cycle against a queue-based bit-stream model plus directed literal checks.
module tb_fifo_p2s_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [2:0]       empty, pop, valid, data, first, last, busy, ready;
    logic [2:0][7:0]  head;
    logic [2:0][15:0] ws;
    for (genvar g = 0; g < 3; g++) begin : ln
        fifo_p2s_serializer_if #(.WIDTH(8)) b ();
        assign b.fifo_empty    = empty[g];
        assign b.fifo_pop_data = head[g];
        assign b.ser_ready     = ready[g];
        assign pop[g]          = b.fifo_pop;
        assign valid[g]        = b.ser_valid;
        assign data[g]         = b.ser_data;
        assign first[g]        = b.ser_first;
        assign last[g]         = b.ser_last;
        fifo_p2s_serializer #(.FIFO_WIDTH(8), .LSB_FIRST(g == 1), .IDLE_GAP(g == 2 ? 2 : 0)) u (
            .clk(clk), .rst(rst), .bus(b), .busy(busy[g]), .words_sent(ws[g])
        );
    end
    logic [7:0] fq[3][$];
    logic [2:0] eb[3][$];
    logic [7:0] sh[3];
    logic [2:0] popd;
    int exp_ws[3], ok_cyc[3], npop[3], nvalid[3], fc[3], lc0[3], pc[3];
    int cyc, ntests, nfail, t;
    function automatic int gap_of(int l);
        return l == 2 ? 2 : 0;
    endfunction
    task automatic chk(string nm, int l, logic [31:0] act, logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s lane%0d cycle %0d: got %0h expected %0h", nm, l, cyc, act, exp);
        end
    endtask
    task automatic refresh();
        for (int l = 0; l < 3; l++) begin
            empty[l] = fq[l].size() == 0;
            head[l]  = fq[l].size() != 0 ? fq[l][0] : 8'h00;
        end
    endtask
    task automatic push(int l, logic [7:0] w);
        fq[l].push_back(w);
        refresh();
    endtask
    task automatic clr();
        for (int l = 0; l < 3; l++) begin
            sh[l] = '0; npop[l] = 0; nvalid[l] = 0; fc[l] = -1; lc0[l] = -1; pc[l] = -1;
        end
    endtask
    // One cycle: compare at negedge against the model, then let the FIFO model consume pops
    task automatic tick();
        logic       ep;
        logic [2:0] f;
        @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            popd[l] = pop[l];
            if (rst) begin
                chk("pop_in_reset", l, pop[l], 0);
                eb[l].delete();
                exp_ws[l] = 0;
                ok_cyc[l] = cyc + 1;
            end else begin
                ep = fq[l].size() != 0 && ((eb[l].size() == 0 && cyc >= ok_cyc[l]) ||
                     (gap_of(l) == 0 && eb[l].size() != 0 && ready[l] && eb[l][0][0]));
                chk("pop", l, pop[l], ep);
                chk("valid", l, valid[l], eb[l].size() != 0);
                chk("words_sent", l, ws[l], exp_ws[l]);
                if (eb[l].size() != 0) begin
                    chk("bit_first_last", l, {data[l], first[l], last[l]}, eb[l][0]);
                    if (ready[l]) begin
                        f = eb[l].pop_front();
                        if (f[0]) begin
                            exp_ws[l] = (exp_ws[l] + 1) & 32'hFFFF;
                            ok_cyc[l] = cyc + 1 + gap_of(l);
                        end
                    end
                end
                if (ep)
                    for (int i = 0; i < 8; i++)
                        eb[l].push_back({(l == 1 ? fq[l][0][i] : fq[l][0][7-i]), (i == 0), (i == 7)});
            end
            if (valid[l]) nvalid[l]++;
            if (pop[l]) begin npop[l]++; pc[l] = cyc; end
            if (valid[l] && ready[l] && !rst) begin
                sh[l] = {sh[l][6:0], data[l]};
                if (first[l]) fc[l] = cyc;
                if (last[l] && lc0[l] < 0) lc0[l] = cyc;
            end
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < 3; l++)
            if (popd[l] && fq[l].size() != 0) void'(fq[l].pop_front());
        refresh();
        cyc++;
    endtask
    initial begin
        ready = '1; head = '0; empty = '1; popd = '0;
        cyc = 0; ntests = 0; nfail = 0;
        for (int l = 0; l < 3; l++) begin exp_ws[l] = 0; ok_cyc[l] = 0; end
        clr();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int l = 0; l < 3; l++) begin
            chk("reset_valid", l, valid[l], 0);
            chk("reset_busy", l, busy[l], 0);
            chk("reset_ws", l, ws[l], 0);
        end
        // Single words: 0xA5 MSB-first, 0x0F LSB-first and MSB-first
        clr(); t = cyc;
        push(0, 8'hA5); push(1, 8'h0F); push(2, 8'h0F);
        repeat (12) tick();
        chk("a_seq", 0, sh[0], 8'hA5);
        chk("a_pops", 0, npop[0], 1);
        chk("a_pop_cycle", 0, pc[0], t);
        chk("a_first", 0, fc[0], t + 1);
        chk("a_last", 0, lc0[0], t + 8);
        chk("a_ws", 0, ws[0], 1);
        chk("a_busy", 0, busy[0], 0);
        chk("b_lsb_seq", 1, sh[1], 8'hF0);
        chk("b_msb_seq", 2, sh[2], 8'h0F);
        // Back-to-back words without a gap
        clr(); t = cyc;
        push(0, 8'hA5); push(0, 8'h3C);
        repeat (20) tick();
        chk("c_valid_cycles", 0, nvalid[0], 16);
        chk("c_pops", 0, npop[0], 2);
        chk("c_second_pop", 0, pc[0], t + 8);
        chk("c_first_last", 0, lc0[0], t + 8);
        chk("c_second_first", 0, fc[0], t + 9);
        chk("c_seq", 0, sh[0], 8'h3C);
        chk("c_ws", 0, ws[0], 3);
        // Three-cycle stall on bit 3
        clr(); t = cyc;
        push(0, 8'hA5);
        repeat (3) tick();
        ready[0] = 1'b0;
        repeat (3) tick();
        ready[0] = 1'b1;
        repeat (12) tick();
        chk("d_last", 0, lc0[0], t + 11);
        chk("d_pops", 0, npop[0], 1);
        chk("d_valid_cycles", 0, nvalid[0], 11);
        chk("d_seq", 0, sh[0], 8'hA5);
        chk("d_ws", 0, ws[0], 4);
        // Idle gap of 2 between two queued words
        clr(); t = cyc;
        push(2, 8'hA5); push(2, 8'h3C);
        repeat (24) tick();
        chk("e_gap", 2, fc[2] - lc0[2] - 1, 3);
        chk("e_pops", 2, npop[2], 2);
        chk("e_second_pop", 2, pc[2], t + 11);
        chk("e_valid_cycles", 2, nvalid[2], 16);
        chk("e_ws", 2, ws[2], 3);
        chk("e_busy", 2, busy[2], 0);
        // Reset in the middle of a word
        clr(); t = cyc;
        push(0, 8'hA5);
        repeat (4) tick();
        chk("f_valid_before", 0, valid[0], 1);
        rst = 1'b1;
        tick();
        chk("f_valid", 0, valid[0], 0);
        chk("f_ws", 0, ws[0], 0);
        chk("f_pop", 0, pop[0], 0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("f_pops", 0, npop[0], 1);
        for (int l = 0; l < 3; l++) chk("f_ws_after", l, ws[l], 0);
        chk("f_busy", 0, busy[0], 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
